// File: rtl/wide_mem_pkg.sv
// Shared word/lane helpers for the 32-bit wide output memory (4 pixels per word).
package wide_mem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    // Word index of a byte address; callers truncate to their word-address width.
    function automatic logic [31:0] word_of(input logic [33:0] baddr);
        return baddr[33:LANE_W];
    endfunction

    // Byte lane within a word; lane n is bits [8n+7:8n] (little-endian).
    function automatic logic [LANE_W-1:0] lane_of(input logic [33:0] baddr);
        return baddr[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/wide_write_packer.sv
// Packs a byte-wide pixel write stream into 32-bit word writes with byte enables.
module wide_write_packer
    import wide_mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          in_we,
    input  logic [AW+1:0] in_waddr,
    input  logic [7:0]    in_wdata,
    input  logic          i_flush,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wbe,
    output logic          o_empty,
    output logic [31:0]   o_word_wr_count,
    output logic [31:0]   o_partial_wr_count
);

    logic          acc_valid_q, acc_valid_d;
    logic [AW-1:0] acc_addr_q,  acc_addr_d;
    logic [31:0]   acc_data_q,  acc_data_d;
    logic [3:0]    acc_be_q,    acc_be_d;
    logic          flush_pending_q, flush_pending_d;

    logic          mem_we_q;
    logic [AW-1:0] mem_waddr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_wbe_q;
    logic [31:0]   word_cnt_q, part_cnt_q;

    logic          emit;
    logic [AW-1:0] emit_addr;
    logic [31:0]   emit_data;
    logic [3:0]    emit_be;

    logic [AW-1:0]     in_word;
    logic [LANE_W-1:0] in_lane;
    logic [31:0]       lane_data;
    logic [3:0]        lane_be;

    assign in_word   = AW'(word_of(34'(in_waddr)));
    assign in_lane   = lane_of(34'(in_waddr));
    assign lane_data = {24'b0, in_wdata} << {in_lane, 3'b000};
    assign lane_be   = 4'b0001 << in_lane;

    // Accumulator next state and the (at most one) word emitted this cycle.
    always_comb begin
        acc_valid_d     = acc_valid_q;
        acc_addr_d      = acc_addr_q;
        acc_data_d      = acc_data_q;
        acc_be_d        = acc_be_q;
        flush_pending_d = flush_pending_q;
        emit            = 1'b0;
        emit_addr       = acc_addr_q;
        emit_data       = acc_data_q;
        emit_be         = acc_be_q;

        if (flush_pending_q) begin
            // Pending word left over from a conflict goes out first; a new
            // byte this cycle opens a fresh accumulator that is not flushed.
            emit            = 1'b1;
            flush_pending_d = 1'b0;
            acc_valid_d     = in_we;
            if (in_we) begin
                acc_addr_d = in_word;
                acc_data_d = lane_data;
                acc_be_d   = lane_be;
            end
        end else begin
            if (in_we) begin
                if (acc_valid_q && in_word == acc_addr_q && !acc_be_q[in_lane]) begin
                    acc_data_d = acc_data_q | lane_data;
                    acc_be_d   = acc_be_q | lane_be;
                end else begin
                    // Word break or repeated lane: old word leaves unchanged.
                    emit       = acc_valid_q;
                    acc_addr_d = in_word;
                    acc_data_d = lane_data;
                    acc_be_d   = lane_be;
                end
                acc_valid_d = 1'b1;
            end
            if (!emit && acc_valid_d && (acc_be_d == 4'hF || i_flush)) begin
                emit        = 1'b1;
                emit_addr   = acc_addr_d;
                emit_data   = acc_data_d;
                emit_be     = acc_be_d;
                acc_valid_d = 1'b0;
            end else if (emit && i_flush && acc_valid_d) begin
                flush_pending_d = 1'b1;
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid_q     <= 1'b0;
            acc_addr_q      <= '0;
            acc_data_q      <= '0;
            acc_be_q        <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            acc_valid_q     <= acc_valid_d;
            acc_addr_q      <= acc_addr_d;
            acc_data_q      <= acc_data_d;
            acc_be_q        <= acc_be_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Registered word-write port; idle cycles drive all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_wbe_q   <= '0;
        end else begin
            mem_we_q    <= emit;
            mem_waddr_q <= emit ? emit_addr : '0;
            mem_wdata_q <= emit ? emit_data : '0;
            mem_wbe_q   <= emit ? emit_be   : '0;
        end
    end

    // Counters step alongside the write they count; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            part_cnt_q <= '0;
        end else if (i_clr) begin
            word_cnt_q <= '0;
            part_cnt_q <= '0;
        end else if (emit) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (emit_be != 4'hF) part_cnt_q <= part_cnt_q + 32'd1;
        end
    end

    assign mem_we             = mem_we_q;
    assign mem_waddr          = mem_waddr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_wbe            = mem_wbe_q;
    assign o_empty            = !acc_valid_q && !flush_pending_q && !mem_we_q;
    assign o_word_wr_count    = word_cnt_q;
    assign o_partial_wr_count = part_cnt_q;

endmodule

// File: tb/tb_wide_write_packer.sv
// Scoreboard bench for wide_write_packer: expected writes queued at stimulus time.
module tb_wide_write_packer;

    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clr = 1'b0;
    logic          in_we = 1'b0;
    logic [AW+1:0] in_waddr = '0;
    logic [7:0]    in_wdata = '0;
    logic          i_flush = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wbe;
    logic          o_empty;
    logic [31:0]   o_word_wr_count;
    logic [31:0]   o_partial_wr_count;

    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    wr_t exp_q[$];

    wide_write_packer #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
        .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .i_flush(i_flush),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .o_empty(o_empty), .o_word_wr_count(o_word_wr_count),
        .o_partial_wr_count(o_partial_wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h be=%b, required no write",
                         mem_waddr, mem_wdata, mem_wbe);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_waddr !== e.addr || mem_wdata !== e.data || mem_wbe !== e.be || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL write: got addr=%0h data=%08h be=%b cyc=%0d, required addr=%0h data=%08h be=%b cyc=%0d",
                             mem_waddr, mem_wdata, mem_wbe, cyc, e.addr, e.data, e.be, e.cyc);
                end
            end
        end
    end

    // One cycle of stimulus: inputs held across one rising edge, then released.
    task automatic step(input logic we, input int addr, input logic [7:0] d,
                        input logic fl, input logic cl);
        in_we    = we;
        in_waddr = (AW+2)'(addr);
        in_wdata = d;
        i_flush  = fl;
        i_clr    = cl;
        @(negedge clk);
        in_we = 1'b0; in_waddr = '0; in_wdata = '0; i_flush = 1'b0; i_clr = 1'b0;
    endtask

    task automatic expect_wr(input int addr, input logic [31:0] data,
                             input logic [3:0] be, input int dly);
        wr_t e;
        e.addr = AW'(addr); e.data = data; e.be = be; e.cyc = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (mem_we !== 1'b0 || mem_waddr !== '0 || mem_wdata !== '0 || mem_wbe !== '0 ||
            o_empty !== 1'b1 || o_word_wr_count !== '0 || o_partial_wr_count !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got we=%b addr=%0h data=%08h be=%b empty=%b wc=%0d pc=%0d, required all 0 with empty=1",
                     mem_we, mem_waddr, mem_wdata, mem_wbe, o_empty, o_word_wr_count, o_partial_wr_count);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_four_bytes;
        step(1'b0, 0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 0, 8'h10, 1'b0, 1'b0);
        step(1'b1, 1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 2, 8'h12, 1'b0, 1'b0);
        expect_wr(0, 32'h13121110, 4'hF, 1);
        step(1'b1, 3, 8'h13, 1'b0, 1'b0);
        idle(2);
        compared++;
        if (o_word_wr_count !== 32'd1 || o_partial_wr_count !== 32'd0 || o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL four_bytes_counts: got wc=%0d pc=%0d empty=%b, required wc=1 pc=0 empty=1",
                     o_word_wr_count, o_partial_wr_count, o_empty);
        end
    endtask

    task automatic test_partial_flush;
        step(1'b0, 0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 5, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 6, 8'hBB, 1'b0, 1'b0);
        compared++;
        if (o_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL partial_buffered_empty: got %b, required 0", o_empty);
        end
        expect_wr(1, 32'h00BBAA00, 4'b0110, 1);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(1);
        compared++;
        if (o_empty !== 1'b1 || o_partial_wr_count !== 32'd1 || o_word_wr_count !== 32'd1) begin
            mismatched++;
            $display("FAIL partial_flush_done: got empty=%b wc=%0d pc=%0d, required empty=1 wc=1 pc=1",
                     o_empty, o_word_wr_count, o_partial_wr_count);
        end
    endtask

    task automatic test_empty_flush;
        logic [31:0] wc;
        wc = o_word_wr_count;
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (o_word_wr_count !== wc || o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL empty_flush: got wc=%0d empty=%b, required wc=%0d empty=1", o_word_wr_count, o_empty, wc);
        end
    endtask

    task automatic test_word_break;
        step(1'b1, 2, 8'h55, 1'b0, 1'b0);
        expect_wr(0, 32'h00550000, 4'b0100, 1);
        step(1'b1, 9, 8'h66, 1'b0, 1'b0);
        idle(3);
        compared++;
        if (o_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL word_break_held: got empty=%b, required 0", o_empty);
        end
        expect_wr(2, 32'h00006600, 4'b0010, 1);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic test_repeated_lane;
        step(1'b1, 4, 8'h01, 1'b0, 1'b0);
        expect_wr(1, 32'h00000001, 4'b0001, 1);
        step(1'b1, 4, 8'h02, 1'b0, 1'b0);
        idle(2);
        expect_wr(1, 32'h00000002, 4'b0001, 1);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic test_conflict_flush;
        step(1'b1, 0, 8'h77, 1'b0, 1'b0);
        expect_wr(0, 32'h00000077, 4'b0001, 1);
        expect_wr(1, 32'h88000000, 4'b1000, 2);
        step(1'b1, 7, 8'h88, 1'b1, 1'b0);
        idle(1);
        compared++;
        if (o_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL conflict_not_yet_empty: got %b, required 0", o_empty);
        end
        idle(1);
        compared++;
        if (o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL conflict_empty: got %b, required 1", o_empty);
        end
    endtask

    task automatic test_pending_then_byte;
        step(1'b1, 0, 8'h21, 1'b0, 1'b0);
        expect_wr(0, 32'h00000021, 4'b0001, 1);
        expect_wr(1, 32'h00002200, 4'b0010, 2);
        step(1'b1, 5, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8, 8'h23, 1'b0, 1'b0);
        idle(3);
        compared++;
        if (o_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL pending_new_byte_held: got empty=%b, required 0", o_empty);
        end
        expect_wr(2, 32'h00000023, 4'b0001, 1);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic test_reset_and_clear;
        step(1'b1, 12, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 13, 8'hC1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        compared++;
        if (mem_we !== 1'b0 || mem_wdata !== '0 || mem_wbe !== '0 || o_empty !== 1'b1 ||
            o_word_wr_count !== '0 || o_partial_wr_count !== '0) begin
            mismatched++;
            $display("FAIL midrun_reset: got we=%b data=%08h be=%b empty=%b wc=%0d pc=%0d, required zeros with empty=1",
                     mem_we, mem_wdata, mem_wbe, o_empty, o_word_wr_count, o_partial_wr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
        // Build one full word, clearing the counters on the emitting cycle.
        step(1'b1, 16, 8'hD0, 1'b0, 1'b0);
        step(1'b1, 17, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 18, 8'hD2, 1'b0, 1'b0);
        expect_wr(4, 32'hD3D2D1D0, 4'hF, 1);
        step(1'b1, 19, 8'hD3, 1'b0, 1'b1);
        compared++;
        if (o_word_wr_count !== '0 || o_partial_wr_count !== '0) begin
            mismatched++;
            $display("FAIL clear_priority: got wc=%0d pc=%0d, required 0 0", o_word_wr_count, o_partial_wr_count);
        end
        idle(2);
        compared++;
        if (o_word_wr_count !== '0 || o_partial_wr_count !== '0) begin
            mismatched++;
            $display("FAIL clear_after: got wc=%0d pc=%0d, required 0 0", o_word_wr_count, o_partial_wr_count);
        end
        // Counting resumes after the clear.
        expect_wr(5, 32'h0000E000, 4'b0010, 1);
        step(1'b1, 21, 8'hE0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (o_word_wr_count !== 32'd1 || o_partial_wr_count !== 32'd1) begin
            mismatched++;
            $display("FAIL count_resume: got wc=%0d pc=%0d, required 1 1", o_word_wr_count, o_partial_wr_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_four_bytes();
        test_partial_flush();
        test_empty_flush();
        test_word_break();
        test_repeated_lane();
        test_conflict_flush();
        test_pending_then_byte();
        test_reset_and_clear();
        idle(3);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_writes: got %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wide_write_packer.md
# wide_write_packer

Packs the byte-wide output pixel stream of the sequential bilinear core (`out_waddr`/`out_wdata`/`out_we`) into 32-bit words for the wide output memory. This mirrors the 32-bit read side, so the output buffer also uses 4 pixels per word. The block sits directly downstream of the bilinear core. It merges consecutive bytes of the same word, emits one word write with byte enables when a word is complete or interrupted, and flushes any partial word on request (tied to the core's `done`).

## Interface
- `AW`, default 10: word-address width of the wide output memory. The byte-address width is `AW+2`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_clr` in 1: one-cycle pulse that clears the performance counters. Tied to the core's `start`.
- `in_we` in 1: byte write strobe from the core.
- `in_waddr` in AW+2: byte (pixel) address.
- `in_wdata` in 8: pixel value.
- `i_flush` in 1: one-cycle pulse that emits any partial word. Tied to the core's `done`.
- `mem_we` out 1: word write strobe, one cycle per word.
- `mem_waddr` out AW: word address.
- `mem_wdata` out 32: word data. Lanes not enabled are driven 0.
- `mem_wbe` out 4: byte enables. Bit n is lane n.
- `o_empty` out 1: high when nothing is buffered or pending.
- `o_word_wr_count` out 32: number of word writes emitted.
- `o_partial_wr_count` out 32: number of emitted words with `mem_wbe != 4'hF`.

## Operation
- **Address split:**
  - word = `in_waddr[AW+1:2]`.
  - lane = `in_waddr[1:0]`.
  - Lane n maps to `mem_wdata[8n+7:8n]` (little-endian), matching the read-side packing.
- **Accumulator state:** `acc_valid`, `acc_addr`, `acc_data[31:0]`, `acc_be[3:0]`, plus a `flush_pending` flag.
- **On `in_we`:**
  - If `!acc_valid`: load a new accumulator holding this byte only.
  - If `acc_valid`, word == `acc_addr`, and `acc_be[lane]` == 0: merge the byte and set `acc_be[lane]`.
  - If `acc_valid` and (word != `acc_addr` or `acc_be[lane]` == 1): emit the current accumulator, then load a new accumulator with this byte. A repeated lane in the same word is never overwritten in place.
  - If the merge or load makes `acc_be` == 4'hF: emit that word and clear `acc_valid`.
- **On `i_flush`:**
  - If there is a single candidate word (either `acc_valid`, or the accumulator just loaded/merged by a same-cycle `in_we`), emit it.
  - If the same-cycle `in_we` already forced an emission (conflict case), emit the old word this cycle and set `flush_pending`. The new accumulator is emitted on the next cycle, which then clears `flush_pending`.
- **Flush with nothing buffered:** no write, no counter change.
- **`in_we` while `flush_pending`:** the pending accumulator is emitted first, exactly as in the conflict case. The new byte starts a fresh accumulator, which is not flushed.
- **Counters:**
  - `o_word_wr_count` increments by 1 per emission.
  - `o_partial_wr_count` increments by 1 when `mem_wbe != 4'hF`.
  - `i_clr` zeroes both counters and takes priority over a same-cycle increment.
  - `i_clr` does not affect the accumulator.
- **`o_empty`** = `!acc_valid && !flush_pending && !mem_we`.
- **Backpressure:** none. The wide memory accepts a write every cycle, and the core produces at most one byte per cycle.

## Timing
- **Reset:** all outputs are 0 (`o_empty` is 1). `acc_valid` and `flush_pending` are 0. Reset mid-operation drops the buffered bytes with no write.
- **Emission latency:** an emission triggered in cycle t drives `mem_we`, `mem_waddr`, `mem_wdata`, and `mem_wbe` from registers in cycle t+1, for exactly one cycle.
- **Throughput:** at most one word write per cycle. Back-to-back emissions are allowed (conflict followed by pending flush).
- **Completion:** after `i_flush`, `o_empty` is high within 2 cycles in the normal case, and within 3 cycles when a conflict forced a pending flush.

## Structure
- A shared package `wide_mem_pkg` holds:
  - `BYTES_PER_WORD = 4`.
  - `LANE_W = 2`.
  - A `word_of()` helper.
  - A `lane_of()` helper.
- The read-side controller uses the same package.
- The block is a single module with no sub-module.

## Test plan
- **Four sequential bytes:** bytes 0x10, 0x11, 0x12, 0x13 at byte addresses 0..3, one per cycle -> a single write with `mem_waddr`=0, `mem_wdata`=0x13121110, `mem_wbe`=4'hF, `mem_we` one cycle after the 4th byte. Counters: words 1, partial 0.
- **Partial flush:** bytes 0xAA at address 5 and 0xBB at address 6, then `i_flush` -> `mem_waddr`=1, `mem_wdata`=0x00BBAA00, `mem_wbe`=4'b0110. Partial count 1. `o_empty`=1 two cycles after the flush.
- **Word break:** byte at address 2, then byte at address 9 -> the first word is emitted (`mem_waddr`=0, `mem_wbe`=4'b0100) the cycle after the second byte. The second byte stays buffered until its word completes or is flushed.
- **Repeated lane:** byte 0x01 at address 4, then 0x02 at address 4 -> a write of word 1 with `mem_wdata`=0x00000001, `mem_wbe`=4'b0001. 0x02 is held in a new accumulator.
- **Conflict plus flush:** byte at address 0, then byte at address 7 together with `i_flush` -> two back-to-back writes: word 0 (`mem_wbe`=4'b0001), then word 1 (`mem_wbe`=4'b1000).
- **Reset and clear:** assert `rst_n` low with 2 bytes buffered -> no write, all outputs 0. Separately, pulse `i_clr` in the same cycle as an emission -> both counters read 0.
